// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller: event codes, channel states
// and the counter sizing helper.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } chan_state_e;

  // Counter must reach max(long, repeat) - 1; never narrower than one bit.
  function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
    int m;
    m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_evt_chan.sv
// One button channel: press/long/repeat FSM, hold counter, one-entry pending
// slot and sticky overrun flag. Auto-repeat enabled by BTN_AUTOREPEAT_EN.
import btn_evt_pkg::*;

module btn_evt_chan #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      level,
  input  logic      drain,
  output logic      pend_valid,
  output evt_code_e pend_code,
  output logic      held,
  output logic      overrun
);

  localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
`endif

  chan_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             raise;
  evt_code_e        code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    raise     = 1'b0;
    code      = EVT_PRESS;
    case (state)
      ST_IDLE: begin
        if (level) begin
          state_nxt = ST_SHORT;
          cnt_nxt   = '0;
          raise     = 1'b1;
          code      = EVT_PRESS;
        end
      end
      ST_SHORT: begin
        if (!level) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          raise     = 1'b1;
          code      = EVT_RELEASE;
        end else if (cnt == LONG_TC) begin
          state_nxt = ST_LONG;
          cnt_nxt   = '0;
          raise     = 1'b1;
          code      = EVT_LONG;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LONG: begin
        // Release wins over a repeat terminal count in the same cycle.
        if (!level) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          raise     = 1'b1;
          code      = EVT_RELEASE;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == REPEAT_TC) begin
            cnt_nxt = '0;
            raise   = 1'b1;
            code    = EVT_REPEAT;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_code  <= EVT_PRESS;
      overrun    <= 1'b0;
    end else if (raise) begin
      pend_valid <= 1'b1;
      pend_code  <= code;
      if (pend_valid && !drain) overrun <= 1'b1;
    end else if (drain) begin
      pend_valid <= 1'b0;
    end
  end

  assign held = (state != ST_IDLE);

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: NUM_BTN channels, round-robin arbiter and output
// register with valid/ready handshake. Auto-repeat enabled by BTN_AUTOREPEAT_EN.
import btn_evt_pkg::*;

module button_event_ctrl #(
  parameter int NUM_BTN       = 4,
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  localparam int ID_W         = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [1:0]         evt_code,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] overrun
);

  logic [NUM_BTN-1:0] pend_valid;
  evt_code_e          pend_code [NUM_BTN];
  logic [NUM_BTN-1:0] drain;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic               load;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_evt_chan #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .level     (btn_level[i]),
      .drain     (drain[i]),
      .pend_valid(pend_valid[i]),
      .pend_code (pend_code[i]),
      .held      (held[i]),
      .overrun   (overrun[i])
    );
    assign drain[i] = load && grant_valid && (grant_idx == ID_W'(i));
  end

  assign load = !evt_valid || evt_ready;

  // Search starts one past the last grant and wraps.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = ptr;
    idx         = 0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (!grant_valid && pend_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_code  <= '0;
      ptr       <= ID_W'(NUM_BTN - 1);
    end else if (load) begin
      evt_valid <= grant_valid;
      if (grant_valid) begin
        evt_id   <= grant_idx;
        evt_code <= pend_code[grant_idx];
        ptr      <= grant_idx;
      end
    end
  end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 4, number of debounced button channels (2..16).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100_000_000, hold time in clk cycles before a LONG event (~1 s @ 100 MHz).
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 20_000_000, auto-repeat period in clk cycles (~200 ms @ 100 MHz).
REQ-004 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port btn_level, input, NUM_BTN, clean (already debounced) button levels, 1 = pressed.
REQ-007 The block SHALL have port evt_valid, output, 1, event present on evt_id/evt_code.
REQ-008 The block SHALL have port evt_ready, input, 1, consumer accepts the event when high with evt_valid.
REQ-009 The block SHALL have port evt_id, output, $clog2(NUM_BTN), channel index of the event.
REQ-010 The block SHALL have port evt_code, output, 2, event code: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
REQ-011 The block SHALL have port held, output, NUM_BTN, per-channel pressed state as tracked by the FSM.
REQ-012 The block SHALL have port overrun, output, NUM_BTN, sticky per-channel lost-event flag.

Function
REQ-013 Each channel SHALL run an FSM with states IDLE, SHORT and LONG, plus a counter of width $clog2(max(LONG_CYCLES,REPEAT_CYCLES)).
- IDLE, level 1: go to SHORT, clear counter, raise PRESS.
- SHORT, level 0: go to IDLE, raise RELEASE.
- SHORT, counter == LONG_CYCLES-1: go to LONG, clear counter, raise LONG. Otherwise increment the counter.
- LONG, level 0: go to IDLE, raise RELEASE. Release takes priority over any terminal count in the same cycle.
REQ-014 held[i] SHALL be 1 exactly when channel i is in SHORT or LONG.
REQ-015 Each channel SHALL own a one-entry pending slot (valid bit + code); a raised event is written to the slot at the same edge as the state transition.
REQ-016 Overrun SHALL behave as follows:
- If the slot is occupied and not being drained that cycle, the new event overwrites it and sets overrun[i].
- Overrun bits clear only on reset.
REQ-017 Drain and new event in the same cycle SHALL store the new event with no overrun.
REQ-018 A round-robin arbiter SHALL select among channels with valid slots.
- Search starts at last-granted index + 1, with wrap-around from NUM_BTN-1 to 0.
- The pointer updates only on grant.
REQ-019 The output register (evt_valid/evt_id/evt_code) SHALL load the granted slot when empty or when evt_valid && evt_ready; loading clears that slot.
REQ-020 Latency SHALL be fixed: a level change sampled at edge k produces evt_valid high after edge k+1 when the output is free.
REQ-021 While evt_valid && !evt_ready, evt_id and evt_code SHALL remain stable.
REQ-022 The accept-and-reload path SHALL sustain one event per cycle.

Reset
REQ-023 reset_n low SHALL asynchronously force the following state:
- all FSMs IDLE, counters 0, slots empty, arbiter pointer NUM_BTN-1;
- evt_valid 0, evt_id 0, evt_code 0, held 0, overrun 0.
REQ-024 Reset mid-hold SHALL discard all state and pending events; a button still high at reset release produces a fresh PRESS on the first clocked edge.

Configuration
REQ-025 With BTN_AUTOREPEAT_EN defined, a channel in LONG SHALL raise REPEAT, clear its counter and stay in LONG whenever counter == REPEAT_CYCLES-1.
REQ-026 Without BTN_AUTOREPEAT_EN, the LONG state SHALL hold its counter at 0, code 3 SHALL never be emitted, and REPEAT_CYCLES SHALL be ignored.

Structure
REQ-027 Package btn_evt_pkg SHALL hold the event-code enum (PRESS/RELEASE/LONG/REPEAT) and the channel state enum (IDLE/SHORT/LONG).
REQ-028 Sub-module btn_evt_chan SHALL implement one channel (FSM, counter, pending slot, overrun bit).
- Instantiated NUM_BTN times by generate.
- Arbiter and output register reside in the top.

Verification (NUM_BTN=4, LONG_CYCLES=8, REPEAT_CYCLES=4, evt_ready=1 unless stated)
REQ-029 Btn0 high for 3 cycles then low -> evt (0,PRESS) two cycles after rise, then (0,RELEASE); no LONG; held[0] high 3 cycles.
REQ-030 Btn2 high for 30 cycles, macro defined -> PRESS, LONG 8 cycles after PRESS, REPEAT every 4 cycles (5 total), RELEASE; without macro -> PRESS, LONG, RELEASE only.
REQ-031 Btns 0,1,3 rise in the same cycle -> PRESS events emitted on consecutive cycles in order 0,1,3; next simultaneous round starts after 3.
REQ-032 evt_ready held 0 for 10 cycles while btn1 presses and releases -> evt (1,PRESS) stays stable; RELEASE overwrites only if the slot was not drained; overrun[1]=1 in that case.
REQ-033 reset_n pulsed low while btn2 is in LONG with an event pending -> all outputs 0 immediately; after release, btn2 still high -> (2,PRESS) with LONG 8 cycles later.
